// File: rtl/crc73_pkg.sv
// crc73_pkg: shared widths, single-error syndromes, framing states and check function for the (7,3) code
package crc73_pkg;
  localparam int CW_W = 7;
  localparam int DATA_W = 3;
  localparam int CRC_W = 4;
  localparam logic [CRC_W-1:0] SYN_D2 = 4'b1011;
  localparam logic [CRC_W-1:0] SYN_D1 = 4'b1110;
  localparam logic [CRC_W-1:0] SYN_D0 = 4'b0111;
  localparam logic [CRC_W-1:0] SYN_C3 = 4'b1000;
  localparam logic [CRC_W-1:0] SYN_C2 = 4'b0100;
  localparam logic [CRC_W-1:0] SYN_C1 = 4'b0010;
  localparam logic [CRC_W-1:0] SYN_C0 = 4'b0001;
  typedef enum logic {S_HUNT, S_RECV} state_t;
  function automatic logic [CRC_W-1:0] crc73_check(input logic [DATA_W-1:0] d);
    return {d[2] ^ d[1], d[1] ^ d[0], d[2] ^ d[1] ^ d[0], d[2] ^ d[0]};
  endfunction
endpackage

// File: rtl/crc73_syndrome.sv
// crc73_syndrome: combinational check recompute, syndrome and (optionally corrected) data for one codeword
// ports: cw codeword in; check recomputed check bits; syndrome check ^ cw[3:0]; data report data; uncorr not a single-bit error
// build option: CRC_CORRECT_EN flips the data bit named by a data-bit syndrome; otherwise data is raw
module crc73_syndrome import crc73_pkg::*; (
  input  logic [CW_W-1:0]   cw,
  output logic [CRC_W-1:0]  check,
  output logic [CRC_W-1:0]  syndrome,
  output logic [DATA_W-1:0] data,
  output logic              uncorr
);
  always_comb begin
    check = crc73_check(cw[CW_W-1:CRC_W]);
    syndrome = check ^ cw[CRC_W-1:0];
`ifdef CRC_CORRECT_EN
    data = cw[CW_W-1:CRC_W] ^ {syndrome == SYN_D2, syndrome == SYN_D1, syndrome == SYN_D0};
    uncorr = (syndrome != '0) && !(syndrome inside {SYN_D2, SYN_D1, SYN_D0, SYN_C3, SYN_C2, SYN_C1, SYN_C0});
`else
    data = cw[CW_W-1:CRC_W];
    uncorr = syndrome != '0;
`endif
  end
endmodule

// File: rtl/crc_check_three_rx.sv
// crc_check_three_rx: serial (7,3) codeword checker with framing, registered per-frame report and saturating error count
// ports: i_clk/i_rst clock and async active-high reset; i_bit/i_bit_vld/i_sync serial bit, valid, frame-start mark;
//        o_data/o_syndrome/o_err/o_uncorr frame report strobed by o_data_vld; o_drop partial-frame discard; o_err_cnt error frames
// build option: CRC_CORRECT_EN (applied inside crc73_syndrome) enables single-bit data correction
module crc_check_three_rx import crc73_pkg::*; #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_bit,
  input  logic                 i_bit_vld,
  input  logic                 i_sync,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_data_vld,
  output logic [CRC_W-1:0]     o_syndrome,
  output logic                 o_err,
  output logic                 o_uncorr,
  output logic                 o_drop,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [CW_W-2:0] sr;
  logic [CW_W-1:0] cw;
  logic [CRC_W-1:0] check, syn;
  logic [DATA_W-1:0] data;
  logic uncorr, start, take, drop, done, err;
  // the bit being sampled completes the codeword when it is cw[0]
  assign cw = {sr, i_bit};
  crc73_syndrome u_syn (
    .cw(cw),
    .check(check),
    .syndrome(syn),
    .data(data),
    .uncorr(uncorr)
  );
  always_comb begin
    start = i_bit_vld & i_sync;
    take = i_bit_vld & (i_sync | (state == S_RECV));
    state_nxt = start ? S_RECV : state;
    cnt_nxt = !take ? cnt : start ? 3'd1 : (cnt == 3'd6) ? 3'd0 : cnt + 3'd1;
  end
  always_comb begin
    drop = start & (cnt != 3'd0);
    done = take & !i_sync & (cnt == 3'd6);
    err = check != cw[CRC_W-1:0];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_HUNT;
      cnt <= '0;
      sr <= '0;
      o_data <= '0;
      o_data_vld <= 1'b0;
      o_syndrome <= '0;
      o_err <= 1'b0;
      o_uncorr <= 1'b0;
      o_drop <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      o_data_vld <= done;
      o_drop <= drop;
      if (take) sr <= start ? {{(CW_W-2){1'b0}}, i_bit} : cw[CW_W-2:0];
      if (done) begin
        o_data <= data;
        o_syndrome <= syn;
        o_err <= err;
        o_uncorr <= uncorr;
        if (err && o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_crc_check_three_rx.sv
// tb_crc_check_three_rx: randomized scoreboard bench for crc_check_three_rx against a parity-check-matrix model
module tb_crc_check_three_rx;
  localparam int W = 8;
  localparam logic [3:0] COL [3] = '{4'b0111, 4'b1110, 4'b1011};
  typedef struct packed {
    logic [2:0]   data;
    logic [3:0]   syn;
    logic         err;
    logic         uncorr;
    logic [W-1:0] cnt;
  } rep_t;
  logic clk = 1'b0;
  logic i_rst, i_bit, i_bit_vld, i_sync;
  logic [2:0] o_data;
  logic [3:0] o_syndrome;
  logic o_data_vld, o_err, o_uncorr, o_drop;
  logic [W-1:0] o_err_cnt;
  rep_t exp_q[$];
  rep_t last;
  int checks = 0, failures = 0;
  int exp_drops = 0, seen_drops = 0, exp_reps = 0, seen_reps = 0;
  int fn = 0;
  logic hunting = 1'b1;
  logic [6:0] fb;
  logic [W-1:0] model_cnt = '0;
  always #5 clk = ~clk;
  crc_check_three_rx #(.ERR_CNT_W(W)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_bit(i_bit),
    .i_bit_vld(i_bit_vld),
    .i_sync(i_sync),
    .o_data(o_data),
    .o_data_vld(o_data_vld),
    .o_syndrome(o_syndrome),
    .o_err(o_err),
    .o_uncorr(o_uncorr),
    .o_drop(o_drop),
    .o_err_cnt(o_err_cnt)
  );
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic logic [3:0] psyn(input int p);
    return p < 4 ? 4'(1 << p) : COL[p-4];
  endfunction
  function automatic logic [3:0] hsyn(input logic [6:0] c);
    logic [3:0] s = '0;
    for (int p = 0; p < 7; p++) if (c[p]) s ^= psyn(p);
    return s;
  endfunction
  function automatic logic [6:0] encode(input logic [2:0] d);
    return {d, hsyn({d, 4'b0})};
  endfunction
  task automatic push_report(input logic [6:0] c);
    rep_t r;
    int pos = -1;
    r.syn = hsyn(c);
    r.err = r.syn != 4'd0;
    for (int p = 0; p < 7; p++) if (r.err && psyn(p) == r.syn) pos = p;
`ifdef CRC_CORRECT_EN
    r.data = c[6:4] ^ ((pos >= 4) ? 3'(1 << (pos - 4)) : 3'd0);
    r.uncorr = r.err && pos < 0;
`else
    r.data = c[6:4];
    r.uncorr = r.err;
`endif
    if (r.err && model_cnt != {W{1'b1}}) model_cnt = model_cnt + 1'b1;
    r.cnt = model_cnt;
    exp_q.push_back(r);
    exp_reps++;
  endtask
  task automatic send_bit(input logic b, input logic s, input int maxgap);
    repeat ($urandom_range(maxgap, 0)) begin
      i_bit_vld = 1'b0;
      i_bit = 1'($urandom);
      i_sync = 1'($urandom);
      @(posedge clk); #1;
    end
    i_bit_vld = 1'b1;
    i_bit = b;
    i_sync = s;
    if (s) begin
      if (fn != 0) exp_drops++;
      fb = {6'd0, b};
      fn = 1;
      hunting = 1'b0;
    end else if (!hunting) begin
      fb = {fb[5:0], b};
      fn++;
      if (fn == 7) begin
        push_report(fb);
        fn = 0;
      end
    end
    @(posedge clk); #1;
    i_bit_vld = 1'b0;
    i_sync = 1'b0;
  endtask
  task automatic send_frame(input logic [6:0] c, input logic s, input int g);
    for (int i = 6; i >= 0; i--) send_bit(c[i], s && i == 6, g);
  endtask
  task automatic send_partial(input int k, input int g);
    for (int i = 0; i < k; i++) send_bit(1'($urandom), i == 0, g);
  endtask
  task automatic check_zero(input string tag);
    cmp({tag, "_data"}, 32'(o_data), 0);
    cmp({tag, "_vld"}, 32'(o_data_vld), 0);
    cmp({tag, "_syn"}, 32'(o_syndrome), 0);
    cmp({tag, "_err"}, 32'(o_err), 0);
    cmp({tag, "_uncorr"}, 32'(o_uncorr), 0);
    cmp({tag, "_drop"}, 32'(o_drop), 0);
    cmp({tag, "_cnt"}, 32'(o_err_cnt), 0);
  endtask
  task automatic model_reset();
    exp_q.delete();
    last = '0;
    model_cnt = '0;
    fn = 0;
    hunting = 1'b1;
  endtask
  always @(negedge clk) begin
    if (!i_rst) begin
      cmp("vld_drop_excl", 32'(o_data_vld & o_drop), 0);
      if (o_drop) seen_drops++;
      if (o_data_vld) begin
        seen_reps++;
        cmp("report_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) last = exp_q.pop_front();
      end
      cmp("data", 32'(o_data), 32'(last.data));
      cmp("syndrome", 32'(o_syndrome), 32'(last.syn));
      cmp("err", 32'(o_err), 32'(last.err));
      cmp("uncorr", 32'(o_uncorr), 32'(last.uncorr));
      cmp("err_cnt", 32'(o_err_cnt), 32'(last.cnt));
    end
  end
  initial begin
    logic [6:0] c;
    int p1, p2, nf;
    last = '0;
    i_rst = 1'b1;
    i_bit = 1'b0;
    i_bit_vld = 1'b0;
    i_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    i_rst = 1'b0;
    send_frame(7'b1011100, 1'b1, 0);
    send_frame(7'b1111100, 1'b1, 0);
    send_frame(7'b0011101, 1'b1, 0);
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_frame(7'b0101110, 1'b1, 0);
    send_frame(7'b1110010, 1'b1, 3);
    send_frame(7'b0010111, 1'b0, 3);
    for (int f = 0; f < 150; f++) begin
      c = encode(3'($urandom));
      nf = $urandom_range(3, 0);
      p1 = $urandom_range(6, 0);
      p2 = (p1 + $urandom_range(6, 1)) % 7;
      if (nf >= 1) c[p1] = ~c[p1];
      if (nf == 2) c[p2] = ~c[p2];
      if ($urandom_range(7, 0) == 0) begin
        send_partial($urandom_range(6, 1), 1);
        send_frame(c, 1'b1, 2);
      end else send_frame(c, 1'($urandom), 2);
    end
    for (int f = 0; f < 260; f++) begin
      c = encode(3'($urandom));
      p1 = $urandom_range(6, 0);
      c[p1] = ~c[p1];
      send_frame(c, 1'b0, 0);
    end
    send_partial(3, 0);
    @(posedge clk);
    #3 i_rst = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    i_rst = 1'b0;
    for (int i = 0; i < 14; i++) send_bit(1'($urandom), 1'b0, 1);
    send_frame(7'b0011101, 1'b1, 1);
    send_frame(encode(3'b110), 1'b0, 1);
    repeat (10) @(posedge clk);
    #1;
    cmp("pending_reports", 32'(exp_q.size()), 0);
    cmp("report_count", 32'(seen_reps), 32'(exp_reps));
    cmp("drop_count", 32'(seen_drops), 32'(exp_drops));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
